// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted two-VC arbiter feeding two destination FIFOs.
// One-cycle read-to-write pipeline with sticky overflow detection.
module vc_arbiter #(
    parameter int BW     = 6,
    parameter int WEIGHT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          VC0_empty,
    input  logic          VC1_empty,
    input  logic [BW-1:0] VC0_data_out,
    input  logic [BW-1:0] VC1_data_out,
    output logic          VC0_rd,
    output logic          VC1_rd,
    input  logic          D0_pause,
    input  logic          D1_pause,
    input  logic          D0_full,
    input  logic          D1_full,
    output logic          D0_wr,
    output logic          D1_wr,
    output logic [BW-1:0] D0_data_in,
    output logic [BW-1:0] D1_data_in,
    output logic [1:0]    state,
    output logic          error_out,
    output logic [7:0]    D0_count,
    output logic [7:0]    D1_count
);

    localparam int SW = (WEIGHT < 1) ? 1 : $clog2(WEIGHT + 1);
    localparam logic [SW-1:0] WMAX = SW'(WEIGHT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [SW-1:0] streak;
    logic          rd_q;
    logic          src_q;
    logic [BW-1:0] word;
    logic          dest;
    logic          pause_any;
    logic          rd_ok;
    logic          grant0;
    logic          grant1;
    logic          overflow;
    logic          at_limit;

    assign state     = state_q;
    assign pause_any = D0_pause | D1_pause;
    assign at_limit  = (streak == WMAX);

    // The in-flight word is the read data of the VC popped last cycle
    assign word     = src_q ? VC1_data_out : VC0_data_out;
    assign dest     = word[BW-2];
    assign overflow = rd_q & (dest ? D1_full : D0_full);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state; an overflow beats every other transition
    always_comb begin
        state_d = state_q;
        if (overflow) begin
            state_d = S_ERROR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!enable)        state_d = S_IDLE;
                    else if (pause_any) state_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (!enable)         state_d = S_IDLE;
                    else if (!pause_any) state_d = S_RUN;
                end
                default: state_d = S_ERROR;
            endcase
        end
    end

    // Outputs: grant selection and destination write steering
    always_comb begin
        rd_ok  = (state_q == S_RUN) & enable & ~pause_any;
        grant0 = rd_ok & ~VC0_empty & ~(at_limit & ~VC1_empty);
        grant1 = rd_ok & ~VC1_empty & (VC0_empty | at_limit);
        VC0_rd = grant0;
        VC1_rd = grant1;
        D0_wr  = rd_q & ~dest & ~D0_full;
        D1_wr  = rd_q &  dest & ~D1_full;
        D0_data_in = (rd_q & ~dest) ? word : '0;
        D1_data_in = (rd_q &  dest) ? word : '0;
    end

    // Read pipeline: remember a pop happened and which VC it hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= 1'b0;
            src_q <= 1'b0;
        end else begin
            rd_q  <= grant0 | grant1;
            src_q <= grant1;
        end
    end

    // VC0 streak: only counts while VC1 is actually waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (VC1_empty || grant1) begin
            streak <= '0;
        end else if (grant0 && !at_limit) begin
            streak <= streak + 1'b1;
        end
    end

    // Sticky error flag and per-destination write counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_out <= 1'b0;
            D0_count  <= 8'd0;
            D1_count  <= 8'd0;
        end else begin
            error_out <= error_out | overflow;
            D0_count  <= D0_count + {7'd0, D0_wr};
            D1_count  <= D1_count + {7'd0, D1_wr};
        end
    end

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed and random stimulus against a queue-based
// behavioural model of the weighted VC arbiter.
module tb_vc_arbiter;

    localparam int BW     = 6;
    localparam int WEIGHT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          VC0_empty;
    logic          VC1_empty;
    logic [BW-1:0] VC0_data_out;
    logic [BW-1:0] VC1_data_out;
    logic          VC0_rd;
    logic          VC1_rd;
    logic          D0_pause;
    logic          D1_pause;
    logic          D0_full;
    logic          D1_full;
    logic          D0_wr;
    logic          D1_wr;
    logic [BW-1:0] D0_data_in;
    logic [BW-1:0] D1_data_in;
    logic [1:0]    state;
    logic          error_out;
    logic [7:0]    D0_count;
    logic [7:0]    D1_count;

    always #5 clk = ~clk;

    vc_arbiter #(.BW(BW), .WEIGHT(WEIGHT)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .VC0_empty    (VC0_empty),
        .VC1_empty    (VC1_empty),
        .VC0_data_out (VC0_data_out),
        .VC1_data_out (VC1_data_out),
        .VC0_rd       (VC0_rd),
        .VC1_rd       (VC1_rd),
        .D0_pause     (D0_pause),
        .D1_pause     (D1_pause),
        .D0_full      (D0_full),
        .D1_full      (D1_full),
        .D0_wr        (D0_wr),
        .D1_wr        (D1_wr),
        .D0_data_in   (D0_data_in),
        .D1_data_in   (D1_data_in),
        .state        (state),
        .error_out    (error_out),
        .D0_count     (D0_count),
        .D1_count     (D1_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus requested for the next cycle
    logic t_reset, t_enable, t_p0, t_p1, t_f0, t_f1;

    // VC FIFO contents and the word each presents after a pop
    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    logic          pv0, pv1;
    logic [BW-1:0] pw0, pw1;

    // Behavioural model
    int            m_st;
    int            m_streak;
    int            m_c0, m_c1;
    bit            m_inf;
    bit            m_err;
    logic [BW-1:0] m_word;

    // Last sampled DUT outputs and event logs
    logic          s_rd0, s_rd1, s_w0, s_w1, s_err;
    logic [1:0]    s_state;
    logic [7:0]    s_c0, s_c1;
    logic [BW-1:0] s_dd0;
    int            g_log[$];
    int            rdc_log[$];
    int            w0c[$];
    int            w1c[$];

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        g_log.delete();
        rdc_log.delete();
        w0c.delete();
        w1c.delete();
    endtask

    // One clock cycle: drive, sample, compare against the model, advance it
    task automatic step();
        int            g;
        bit            ov;
        int            x0, x1, xw0, xw1;
        bit            ok;
        logic [BW-1:0] w;
        @(negedge clk);
        cyc++;
        reset        = t_reset;
        enable       = t_enable;
        D0_pause     = t_p0;
        D1_pause     = t_p1;
        D0_full      = t_f0;
        D1_full      = t_f1;
        VC0_empty    = (q0.size() == 0);
        VC1_empty    = (q1.size() == 0);
        VC0_data_out = pv0 ? pw0 : BW'($urandom);
        VC1_data_out = pv1 ? pw1 : BW'($urandom);
        #1;
        s_rd0   = VC0_rd;
        s_rd1   = VC1_rd;
        s_w0    = D0_wr;
        s_w1    = D1_wr;
        s_err   = error_out;
        s_state = state;
        s_c0    = D0_count;
        s_c1    = D1_count;
        s_dd0   = D0_data_in;
        if (VC0_rd || VC1_rd) begin
            g_log.push_back(VC1_rd ? 1 : 0);
            rdc_log.push_back(cyc);
        end
        if (D0_wr) w0c.push_back(cyc);
        if (D1_wr) w1c.push_back(cyc);

        if (t_reset) begin
            m_st = 0; m_streak = 0; m_inf = 0;
            m_err = 0; m_c0 = 0; m_c1 = 0;
        end
        g = -1; ov = 0;
        x0 = 0; x1 = 0; xw0 = 0; xw1 = 0;
        if (m_inf) begin
            if (m_word[BW-2] == 1'b0) begin
                x0 = int'(m_word);
                if (t_f0) ov = 1; else xw0 = 1;
            end else begin
                x1 = int'(m_word);
                if (t_f1) ov = 1; else xw1 = 1;
            end
        end
        ok = (m_st == 1) && t_enable && !t_p0 && !t_p1;
        if (ok) begin
            if (q0.size() > 0 && !(m_streak == WEIGHT && q1.size() > 0)) g = 0;
            else if (q1.size() > 0) g = 1;
        end

        chk("VC0_rd", int'(VC0_rd), int'(g == 0));
        chk("VC1_rd", int'(VC1_rd), int'(g == 1));
        chk("D0_wr", int'(D0_wr), xw0);
        chk("D1_wr", int'(D1_wr), xw1);
        chk("D0_data_in", int'(D0_data_in), x0);
        chk("D1_data_in", int'(D1_data_in), x1);
        chk("state", int'(state), m_st);
        chk("error_out", int'(error_out), int'(m_err));
        chk("D0_count", int'(D0_count), m_c0);
        chk("D1_count", int'(D1_count), m_c1);

        pv0 = 0; pv1 = 0;
        if (!t_reset) begin
            if (q1.size() == 0 || g == 1) m_streak = 0;
            else if (g == 0 && m_streak < WEIGHT) m_streak++;
            if (ov || m_st == 3)   m_st = 3;
            else if (!t_enable)    m_st = 0;
            else if (m_st == 0)    m_st = 1;
            else if (t_p0 || t_p1) m_st = 2;
            else                   m_st = 1;
            m_err = m_err | ov;
            m_c0  = (m_c0 + xw0) % 256;
            m_c1  = (m_c1 + xw1) % 256;
            m_inf = 0;
            if (g == 0) begin
                w = q0.pop_front();
                pv0 = 1; pw0 = w; m_inf = 1; m_word = w;
            end else if (g == 1) begin
                w = q1.pop_front();
                pv1 = 1; pw1 = w; m_inf = 1; m_word = w;
            end
        end
    endtask

    task automatic drain(int maxc, string nm);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_inf) && n < maxc) begin
            step();
            n++;
        end
        chk({nm, "_drain"}, int'(q0.size() > 0 || q1.size() > 0 || m_inf), 0);
    endtask

    task automatic do_reset();
        t_reset = 1;
        step();
        q0.delete();
        q1.delete();
        t_reset = 0;
    endtask

    initial begin
        int            exp_g[16];
        int            n;
        logic [BW-1:0] w;

        reset = 1; enable = 0;
        D0_pause = 0; D1_pause = 0; D0_full = 0; D1_full = 0;
        VC0_empty = 1; VC1_empty = 1;
        VC0_data_out = '0; VC1_data_out = '0;
        t_reset = 1; t_enable = 0;
        t_p0 = 0; t_p1 = 0; t_f0 = 0; t_f1 = 0;
        pv0 = 0; pv1 = 0; pw0 = '0; pw1 = '0;
        m_st = 0; m_streak = 0; m_c0 = 0; m_c1 = 0;
        m_inf = 0; m_err = 0; m_word = '0;

        step();
        step();
        chk("rst_state", int'(s_state), 0);
        chk("rst_err", int'(s_err), 0);
        chk("rst_count", int'(s_c0), 0);
        t_reset = 0;

        // Three VC0 words, VC1 empty: back-to-back pops, routed by bit4
        clear_logs();
        q0.push_back(6'b10_0001);
        q0.push_back(6'b11_1111);
        q0.push_back(6'b10_0010);
        t_enable = 1;
        for (int i = 0; i < 6; i++) step();
        chk("a_reads", g_log.size(), 3);
        chk("a_consec", rdc_log.size() == 3 ? rdc_log[2] - rdc_log[0] : -1, 2);
        chk("a_d0_writes", w0c.size(), 2);
        chk("a_d1_writes", w1c.size(), 1);
        chk("a_d0_lag", w0c.size() > 0 && rdc_log.size() > 0 ? w0c[0] - rdc_log[0] : -1, 1);
        chk("a_d1_lag", w1c.size() > 0 && rdc_log.size() > 1 ? w1c[0] - rdc_log[1] : -1, 1);
        chk("a_c0", int'(s_c0), 2);
        chk("a_c1", int'(s_c1), 1);

        // Both VCs loaded: weighted grant order
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(BW'($urandom));
            q1.push_back(BW'($urandom));
        end
        drain(60, "b");
        exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        chk("b_grants", g_log.size(), 16);
        for (int i = 0; i < 16; i++)
            chk("b_grant_seq", i < g_log.size() ? g_log[i] : -1, exp_g[i]);

        // D1_pause for three cycles mid-stream
        for (int i = 0; i < 6; i++) q0.push_back(BW'($urandom));
        step();
        step();
        t_p1 = 1;
        step();
        chk("c_p1_state", int'(s_state), 1);
        chk("c_p1_nord", int'(s_rd0 | s_rd1), 0);
        chk("c_p1_inflight", int'(s_w0 | s_w1), 1);
        step();
        chk("c_p2_state", int'(s_state), 2);
        step();
        chk("c_p3_nord", int'(s_rd0 | s_rd1), 0);
        t_p1 = 0;
        step();
        chk("c_r0_state", int'(s_state), 2);
        step();
        chk("c_r1_state", int'(s_state), 1);
        chk("c_r1_rd", int'(s_rd0), 1);
        drain(40, "c");

        // Destination full when a D0 word lands
        for (int i = 0; i < 3; i++) begin
            w = BW'($urandom);
            w[BW-2] = 1'b0;
            q0.push_back(w);
        end
        t_f0 = 1;
        step();
        chk("d_rd", int'(s_rd0), 1);
        step();
        chk("d_no_wr", int'(s_w0), 0);
        step();
        chk("d_state", int'(s_state), 3);
        chk("d_err", int'(s_err), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("d_no_rd", int'(s_rd0 | s_rd1), 0);
        end
        t_f0 = 0;
        do_reset();

        // 256 D0 writes wrap the counter
        clear_logs();
        for (int i = 0; i < 256; i++) begin
            w = BW'($urandom);
            w[BW-2] = 1'b0;
            q0.push_back(w);
        end
        drain(400, "e");
        step();
        chk("e_writes", w0c.size(), 256);
        chk("e_wrap", int'(s_c0), 0);

        // Reset one cycle after a pop discards the in-flight word
        q0.push_back(6'b00_0101);
        q0.push_back(6'b00_0110);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_rd0 && n < 10);
        chk("f_rd_seen", int'(s_rd0), 1);
        t_reset = 1;
        step();
        chk("f_no_wr0", int'(s_w0), 0);
        chk("f_no_wr1", int'(s_w1), 0);
        chk("f_state", int'(s_state), 0);
        chk("f_data", int'(s_dd0), 0);
        q0.delete();
        t_reset = 0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            t_reset  = (m_st == 3) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 299) == 0);
            t_enable = ($urandom_range(0, 9) != 0);
            t_p0     = ($urandom_range(0, 9) == 0);
            t_p1     = ($urandom_range(0, 9) == 0);
            t_f0     = ($urandom_range(0, 24) == 0);
            t_f1     = ($urandom_range(0, 24) == 0);
            if (q0.size() < 6 && $urandom_range(0, 1) == 0)
                q0.push_back(BW'($urandom));
            if (q1.size() < 6 && $urandom_range(0, 2) == 0)
                q1.push_back(BW'($urandom));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameters SHALL be: BW, default 6, word width; WEIGHT, default 4, maximum consecutive VC0 grants while VC1 waits.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 enable  in  1  run permission from the main control FSM (active state).
REQ-005 VC0_empty, VC1_empty  in  1 each  VC FIFO empty flags.
REQ-006 VC0_data_out, VC1_data_out  in  BW each  VC FIFO read data, valid the cycle after the read strobe.
REQ-007 VC0_rd, VC1_rd  out  1 each  VC FIFO pop strobes.
REQ-008 D0_pause, D1_pause  in  1 each  destination almost-full, from the threshold logic.
REQ-009 D0_full, D1_full  in  1 each  destination FIFO full flags.
REQ-010 D0_wr, D1_wr  out  1 each  destination FIFO push strobes.
REQ-011 D0_data_in, D1_data_in  out  BW each  destination write data.
REQ-012 state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, ERROR=3.
REQ-013 error_out  out  1  sticky overflow error.
REQ-014 D0_count, D1_count  out  8 each  words written per destination.

Function
REQ-015 The FSM SHALL transition IDLE->RUN when enable=1.
REQ-016 The FSM SHALL transition RUN->PAUSE when D0_pause|D1_pause=1, and PAUSE->RUN when both pause inputs are 0.
REQ-017 The FSM SHALL transition RUN/PAUSE->IDLE when enable=0.
REQ-018 The FSM SHALL enter ERROR from any state on an overflow event (REQ-025), which takes priority over all other transitions.
REQ-019 ERROR SHALL be left only by reset.
REQ-020 A read SHALL be issued only when state=RUN, enable=1, D0_pause=0, D1_pause=0 and the selected VC is non-empty; at most one of VC0_rd/VC1_rd SHALL be high per cycle, and neither SHALL ever assert for an empty FIFO.
REQ-021 Arbitration: VC0 wins when non-empty unless streak=WEIGHT and VC1 is non-empty, in which case VC1 wins; VC1 wins when VC0 is empty and VC1 is non-empty.
REQ-022 The streak counter (width ceil(log2(WEIGHT+1))) SHALL increment on each VC0 grant while VC1 is non-empty, clear on a VC1 grant or when VC1 is empty, and saturate at WEIGHT.
REQ-023 Pipeline: a read in cycle N SHALL register rd_q=1 and src_q=VC; in cycle N+1 word=VCsrc_data_out and dest=word[BW-2] (0->D0, 1->D1).
REQ-024 In cycle N+1, Ddest_wr SHALL be 1 and Ddest_data_in=word combinationally, giving one cycle of latency from rd to wr.
REQ-025 If Ddest_full=1 in cycle N+1, Ddest_wr SHALL stay 0, the word SHALL be dropped, error_out SHALL be set at the next edge, and state SHALL become ERROR.
REQ-026 An in-flight word SHALL still be written when pause asserts or enable falls in cycle N+1.
REQ-027 No new read SHALL be issued in ERROR, IDLE or PAUSE.
REQ-028 Unselected Dx_data_in SHALL be 0, and Dx_wr SHALL be 0 when not writing.
REQ-029 Dx_count SHALL increment on each Dx_wr and wrap 255->0.

Reset
REQ-030 While reset=1: state=IDLE, error_out=0, streak=0, rd_q=0, counts=0, all rd/wr strobes 0 and data outputs 0.
REQ-031 Reset asserted mid-transfer SHALL discard the in-flight word with no write.
REQ-032 After reset release the block SHALL resume from IDLE.

Verification
REQ-033 VC0 holds 3 words, VC1 empty, enable=1 -> VC0_rd on 3 consecutive cycles; D writes lag by 1 cycle and are routed by bit4 (6'b10_0001->D0, 6'b11_1111->D1).
REQ-034 Both VCs hold 8 words, WEIGHT=4 -> grant order 0,0,0,0,1,0,0,0,0,1...
REQ-035 D1_pause=1 for 3 cycles during streaming -> state=2, no rd, in-flight word written; reads resume the cycle after pause drops.
REQ-036 D0_full=1 when a D0-bound word lands -> D0_wr=0, error_out=1, state=3, no further reads until reset.
REQ-037 Write 256 words to D0 -> D0_count wraps to 0.
REQ-038 Reset asserted one cycle after VC0_rd -> no D write, all outputs 0, state=0.
